// File: rtl/count_ctrl_pkg.sv
// Shared calculator definitions: state encodings and default widths/limits
// used by the iteration controller and its companion up/down counter.
package count_ctrl_pkg;

  localparam int CC_DW_DEF = 4;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LOAD = 3'd1;
  localparam logic [2:0] S_RUN  = 3'd2;
  localparam logic [2:0] S_DONE = 3'd3;
  localparam logic [2:0] S_ERR  = 3'd4;

  // Largest representable count for a given width.
  function automatic int cc_limit_def(input int w);
    return (1 << w) - 1;
  endfunction

endpackage

// File: rtl/ud_counter.sv
// Loadable up/down counter driven by count_ctrl; Q is fed back to the
// controller so it can detect the last iteration and counter faults.
module ud_counter
  import count_ctrl_pkg::*;
#(
  parameter int Data_width = CC_DW_DEF
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  LD,
  input  logic                  UD,
  input  logic                  CE,
  input  logic [Data_width-1:0] D,
  output logic [Data_width-1:0] Q
);

  logic [Data_width-1:0] cnt_q, cnt_d;

  // Load wins over count so LOAD (LD=1, CE=1) presets the value.
  always_comb begin
    cnt_d = cnt_q;
    if (LD)      cnt_d = D;
    else if (CE) cnt_d = UD ? cnt_q + 1'b1 : cnt_q - 1'b1;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign Q = cnt_q;

endmodule

// File: rtl/count_ctrl.sv
// Iteration controller: loads N into an external down counter, strobes STEP
// once per iteration until the counter reaches 1, and flags bad N or counter faults.
module count_ctrl
  import count_ctrl_pkg::*;
#(
  parameter int Data_width = CC_DW_DEF,
  parameter int LIMIT      = cc_limit_def(Data_width)
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  GO,
  input  logic [Data_width-1:0] N,
  input  logic [Data_width-1:0] Q,
  output logic                  LD,
  output logic                  UD,
  output logic                  CE,
  output logic [Data_width-1:0] D,
  output logic                  STEP,
  output logic                  BUSY,
  output logic                  DONE,
  output logic                  ERR
);

  localparam logic [Data_width-1:0] Q_ONE = Data_width'(1);

  logic [2:0]            state_q, state_d;
  logic [Data_width-1:0] nreg_q, nreg_d;
  logic                  n_ok, q_last, q_fault;

  assign n_ok    = (N != '0) && (int'(N) <= LIMIT);
  assign q_last  = (Q == Q_ONE);
  // A counter at 0 or above the loaded count can never reach 1 by counting down.
  assign q_fault = (Q == '0) || (Q > nreg_q);

  always_comb begin
    state_d = state_q;
    nreg_d  = nreg_q;
    case (state_q)
      S_IDLE: begin
        if (GO) begin
          if (n_ok) begin
            nreg_d  = N;
            state_d = S_LOAD;
          end else begin
            state_d = S_ERR;
          end
        end
      end
      S_LOAD: state_d = S_RUN;
      S_RUN: begin
        if (q_fault)     state_d = S_ERR;
        else if (q_last) state_d = S_DONE;
      end
      S_DONE, S_ERR: begin
        if (!GO) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_IDLE;
      nreg_q  <= '0;
    end else begin
      state_q <= state_d;
      nreg_q  <= nreg_d;
    end
  end

  assign LD   = (state_q == S_LOAD);
  assign UD   = 1'b0;
  assign CE   = (state_q == S_LOAD) || ((state_q == S_RUN) && !q_last && !q_fault);
  assign D    = nreg_q;
  assign STEP = (state_q == S_RUN);
  assign BUSY = (state_q == S_LOAD) || (state_q == S_RUN);
  assign DONE = (state_q == S_DONE);
  assign ERR  = (state_q == S_ERR);

endmodule

// File: tb/tb_count_ctrl.sv
// Scoreboard bench: two controller/counter pairs (LIMIT 15 and 9); each driven
// cycle pushes the outputs the block must show in that cycle, checked at negedge.
module tb_count_ctrl;

  localparam logic [6:0] F_IDLE    = 7'b0000000; // LD UD CE STEP BUSY DONE ERR
  localparam logic [6:0] F_LOAD    = 7'b1010100;
  localparam logic [6:0] F_RUN_CE  = 7'b0011100;
  localparam logic [6:0] F_RUN_NCE = 7'b0001100;
  localparam logic [6:0] F_DONE    = 7'b0000010;
  localparam logic [6:0] F_ERR     = 7'b0000001;

  typedef struct {
    logic       sel;
    logic [6:0] fl;
    logic [3:0] d;
    logic       qchk;
    logic [3:0] q;
    string      tag;
  } exp_t;

  logic CLK, RST;
  logic go_a, go_b, qf_en;
  logic [3:0] n_a, n_b, qf_val;

  logic LD_a, UD_a, CE_a, STEP_a, BUSY_a, DONE_a, ERR_a;
  logic [3:0] D_a, cq_a, qin_a;
  logic LD_b, UD_b, CE_b, STEP_b, BUSY_b, DONE_b, ERR_b;
  logic [3:0] D_b, cq_b;

  exp_t sbq[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  assign qin_a = qf_en ? qf_val : cq_a;

  count_ctrl #(.Data_width(4)) u_ctrl_a (
    .CLK(CLK), .RST(RST), .GO(go_a), .N(n_a), .Q(qin_a),
    .LD(LD_a), .UD(UD_a), .CE(CE_a), .D(D_a), .STEP(STEP_a),
    .BUSY(BUSY_a), .DONE(DONE_a), .ERR(ERR_a));
  ud_counter #(.Data_width(4)) u_cnt_a (
    .CLK(CLK), .RST(RST), .LD(LD_a), .UD(UD_a), .CE(CE_a), .D(D_a), .Q(cq_a));

  count_ctrl #(.Data_width(4), .LIMIT(9)) u_ctrl_b (
    .CLK(CLK), .RST(RST), .GO(go_b), .N(n_b), .Q(cq_b),
    .LD(LD_b), .UD(UD_b), .CE(CE_b), .D(D_b), .STEP(STEP_b),
    .BUSY(BUSY_b), .DONE(DONE_b), .ERR(ERR_b));
  ud_counter #(.Data_width(4)) u_cnt_b (
    .CLK(CLK), .RST(RST), .LD(LD_b), .UD(UD_b), .CE(CE_b), .D(D_b), .Q(cq_b));

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  always @(negedge CLK) begin
    if (sbq.size() != 0) begin
      exp_t e;
      logic [6:0] of;
      logic [3:0] od, oq;
      e = sbq.pop_front();
      if (e.sel) begin
        of = {LD_b, UD_b, CE_b, STEP_b, BUSY_b, DONE_b, ERR_b};
        od = D_b; oq = cq_b;
      end else begin
        of = {LD_a, UD_a, CE_a, STEP_a, BUSY_a, DONE_a, ERR_a};
        od = D_a; oq = qin_a;
      end
      chk($sformatf("%s/flags", e.tag), 32'(of), 32'(e.fl));
      chk($sformatf("%s/D", e.tag), 32'(od), 32'(e.d));
      if (e.qchk) chk($sformatf("%s/Q", e.tag), 32'(oq), 32'(e.q));
    end
  end

  // One cycle: drive inputs just after the edge, queue what this cycle must show.
  task automatic step(input logic sel, input logic rst, input logic go, input logic [3:0] n,
                      input logic [4:0] qf, input logic [6:0] fl, input logic [3:0] d,
                      input logic qchk, input logic [3:0] q, input string tag);
    exp_t e;
    @(posedge CLK);
    #1;
    RST = rst;
    if (sel) begin go_b = go; n_b = n; end
    else begin go_a = go; n_a = n; end
    qf_en  = qf[4];
    qf_val = qf[3:0];
    e.sel = sel; e.fl = fl; e.d = d; e.qchk = qchk; e.q = q; e.tag = tag;
    sbq.push_back(e);
  endtask

  // Successful operation; N is scrambled to 0 after GO to show it is ignored.
  task automatic op(input logic sel, input int n, input int prev);
    step(sel, 0, 1, 4'(n), 0, F_IDLE, 4'(prev), 0, 0, $sformatf("op%0d_go", n));
    step(sel, 0, 1, 4'd0, 0, F_LOAD, 4'(n), 0, 0, $sformatf("op%0d_load", n));
    for (int i = n; i >= 1; i--)
      step(sel, 0, 1, 4'd0, 0, (i != 1) ? F_RUN_CE : F_RUN_NCE, 4'(n), 1, 4'(i),
           $sformatf("op%0d_run%0d", n, i));
    step(sel, 0, 1, 4'd0, 0, F_DONE, 4'(n), 1, 4'd1, $sformatf("op%0d_done", n));
    step(sel, 0, 0, 4'd0, 0, F_DONE, 4'(n), 1, 4'd1, $sformatf("op%0d_hold", n));
    step(sel, 0, 0, 4'd0, 0, F_IDLE, 4'(n), 0, 0, $sformatf("op%0d_idle", n));
  endtask

  initial begin
    RST = 1'b1; go_a = 0; go_b = 0; n_a = 0; n_b = 0; qf_en = 0; qf_val = 0;
    step(0, 1, 0, 0, 0, F_IDLE, 0, 1, 0, "rst_a");
    step(1, 0, 0, 0, 0, F_IDLE, 0, 1, 0, "rst_b");

    op(0, 5, 0);
    op(0, 1, 5);

    // N=0 rejected; ERR holds while GO is high
    step(0, 0, 1, 0, 0, F_IDLE, 1, 0, 0, "n0_go");
    step(0, 0, 1, 0, 0, F_ERR,  1, 0, 0, "n0_err1");
    step(0, 0, 1, 0, 0, F_ERR,  1, 0, 0, "n0_err2");
    step(0, 0, 0, 0, 0, F_ERR,  1, 0, 0, "n0_err3");
    step(0, 0, 0, 0, 0, F_IDLE, 1, 0, 0, "n0_idle");

    // LIMIT=9: N=12 rejected, N=9 accepted
    step(1, 0, 1, 12, 0, F_IDLE, 0, 0, 0, "lim_go12");
    step(1, 0, 0, 0,  0, F_ERR,  0, 0, 0, "lim_err");
    step(1, 0, 0, 0,  0, F_IDLE, 0, 0, 0, "lim_idle");
    op(1, 9, 0);

    // N=15 aborted by async reset in RUN cycle 6
    step(0, 0, 1, 15, 0, F_IDLE, 1, 0, 0, "rst15_go");
    step(0, 0, 1, 0,  0, F_LOAD, 15, 0, 0, "rst15_load");
    for (int i = 15; i >= 12; i--)
      step(0, 0, 1, 0, 0, F_RUN_CE, 15, 1, 4'(i), $sformatf("rst15_run%0d", i));
    step(0, 1, 0, 0, 0, F_IDLE, 0, 1, 0, "rst15_async");
    step(0, 1, 0, 0, 0, F_IDLE, 0, 1, 0, "rst15_held");
    step(0, 0, 0, 0, 0, F_IDLE, 0, 1, 0, "rst15_rel");
    step(0, 0, 0, 0, 0, F_IDLE, 0, 1, 0, "rst15_quiet");
    op(0, 3, 0);

    // N=6, counter forced to 0 in cycle 4
    step(0, 0, 1, 6, 0, F_IDLE, 3, 0, 0, "f0_go");
    step(0, 0, 1, 0, 0, F_LOAD, 6, 0, 0, "f0_load");
    step(0, 0, 1, 0, 0, F_RUN_CE, 6, 1, 6, "f0_run6");
    step(0, 0, 1, 0, 0, F_RUN_CE, 6, 1, 5, "f0_run5");
    step(0, 0, 1, 0, 5'h10, F_RUN_NCE, 6, 1, 0, "f0_fault");
    step(0, 0, 0, 0, 0, F_ERR,  6, 0, 0, "f0_err");
    step(0, 0, 0, 0, 0, F_IDLE, 6, 0, 0, "f0_idle");

    // N=2, counter forced above nreg
    step(0, 0, 1, 2, 0, F_IDLE, 6, 0, 0, "fhi_go");
    step(0, 0, 1, 0, 0, F_LOAD, 2, 0, 0, "fhi_load");
    step(0, 0, 1, 0, 5'h17, F_RUN_NCE, 2, 1, 7, "fhi_fault");
    step(0, 0, 0, 0, 0, F_ERR,  2, 0, 0, "fhi_err");
    step(0, 0, 0, 0, 0, F_IDLE, 2, 0, 0, "fhi_idle");

    @(negedge CLK);
    #1;
    chk("sb_drained", 32'(sbq.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/count_ctrl.md
COUNT_CTRL -- requirements
Module: count_ctrl

Interface
REQ-001 Parameter SHALL be Data_width, default 4, the width of the count and load value.
REQ-002 Parameter SHALL be LIMIT, default 2**Data_width-1, the largest accepted N.
REQ-003 CLK  input  1  clock; all state changes on rising edge.
REQ-004 RST  input  1  reset, asynchronous, active-high.
REQ-005 GO  input  1  start request, level; sampled only in IDLE, DONE and ERR.
REQ-006 N  input  Data_width  iteration count; sampled in the IDLE cycle where GO=1.
REQ-007 Q  input  Data_width  present value from the downstream up/down counter.
REQ-008 LD  output  1  counter load enable.
REQ-009 UD  output  1  counter direction; 1=up, 0=down.
REQ-010 CE  output  1  counter count enable.
REQ-011 D  output  Data_width  counter load value.
REQ-012 STEP  output  1  one-cycle-per-iteration strobe to the datapath.
REQ-013 BUSY  output  1  high in LOAD and RUN.
REQ-014 DONE  output  1  high in DONE state.
REQ-015 ERR  output  1  high in ERR state.

Function
REQ-016 The block SHALL be a Moore FSM with states IDLE, LOAD, RUN, DONE and ERR; all outputs SHALL decode from state and registered N, except that CE in RUN also depends on Q.
REQ-017 IDLE: with GO=1 and 1<=N<=LIMIT, the FSM SHALL register N into an internal register nreg and go to LOAD.
REQ-018 IDLE: with GO=1 and either N=0 or N>LIMIT, the FSM SHALL go to ERR.
REQ-019 IDLE: with GO=0, the FSM SHALL stay in IDLE.
REQ-020 LOAD: LD=1, CE=1, UD=0, D=nreg, BUSY=1, STEP=0; the FSM SHALL go to RUN after one cycle.
REQ-021 RUN: STEP=1, BUSY=1, UD=0, LD=0 every cycle.
REQ-022 RUN: CE SHALL be 1 when Q!=1, and 0 when Q==1.
REQ-023 RUN: when Q==1, the FSM SHALL go to DONE on the next edge; otherwise it SHALL stay in RUN.
REQ-024 STEP SHALL pulse exactly nreg times per operation.
REQ-025 Latency: GO sampled at edge 0, then LOAD in cycle 1, RUN in cycles 2..N+1, DONE from cycle N+2.
REQ-026 DONE and ERR SHALL hold until GO=0 is sampled, then return to IDLE; a new operation needs GO to drop and rise again.
REQ-027 GO changes and N changes during LOAD and RUN SHALL be ignored.
REQ-028 D SHALL equal nreg in every state; nreg SHALL change only on the IDLE to LOAD transition.
REQ-029 Q==0 or Q>nreg in RUN (counter fault) SHALL cause a transition to ERR, with CE=0 in that cycle.
REQ-030 In IDLE, DONE and ERR, LD, CE, STEP and BUSY SHALL all be 0.

Reset
REQ-031 RST=1 SHALL immediately force state to IDLE and nreg to 0, independent of CLK.
REQ-032 During reset, LD=UD=CE=STEP=BUSY=DONE=ERR=0 and D=0.
REQ-033 RST asserted mid-RUN SHALL abort the operation with no further STEP pulses; the first operation after RST deasserts SHALL need a fresh GO.

Structure
REQ-034 The state encoding constants and the LIMIT default SHALL live in the shared calculator package.
REQ-035 No sub-module SHALL be used; the block is a single FSM plus the nreg register.
REQ-036 At top level, ud_counter SHALL be instantiated beside this block, with Q fed back to this block's Q input.

Verification
REQ-037 Bench SHALL pair the block with ud_counter (Data_width=4), with these directed scenarios:
- N=5, GO pulse held high -> LD one cycle with D=5; STEP high 5 cycles; Q sequence 5,4,3,2,1; DONE at cycle 7; IDLE after GO=0.
- N=1 -> LOAD, then a single RUN cycle with CE=0 and STEP=1; DONE at cycle 3; Q=1.
- N=0 -> ERR the next cycle, no LD or STEP; ERR holds while GO=1 and clears to IDLE after GO=0.
- LIMIT=9, N=12 -> ERR; then GO=0, GO=1 with N=9 -> 9 STEP pulses, then DONE.
- N=15, RST pulsed in RUN cycle 6 -> all outputs 0 asynchronously; no STEP afterward; a new GO with N=3 gives 3 STEP pulses.
- N=6, counter Q forced to 0 in cycle 4 -> ERR next cycle, CE=0, STEP stops.
